player_motion_ctrl: RTL and testbench

Sequences the player paddle's horizontal position from the two raw push-buttons, ticking on the 1 ms game clock.
- Debounces both buttons and arbitrates left/right requests (last-pressed wins).
- Paces steps with a slow-to-fast speed ramp and clamps the position to the playfield.
- A small game-state FSM gates motion (idle/play/freeze/recenter).
- Its outputs x_player/y_player feed the VGA renderer and collision logic directly.

---
 rtl/player_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 46 ++++
 rtl/player_motion_ctrl.sv | 168 ++++++++++++++++
 tb/tb_player_motion_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_pkg.sv
// Shared types and playfield constants for the player paddle motion controller.
package player_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        FREEZE   = 2'd2,
        RECENTER = 2'd3
    } ctrl_state_t;

    localparam int PF_X_MIN      = 265;
    localparam int PF_X_MAX      = 613;
    localparam int PADDLE_W      = 50;
    localparam int PADDLE_HOME_X = 300;
    localparam int PADDLE_HOME_Y = 420;

    // One-pixel step in the requested direction, pinned to [lo, hi].
    function automatic logic [15:0] step_clamp(input logic [15:0] x,
                                               input logic        right,
                                               input logic [15:0] lo,
                                               input logic [15:0] hi);
        if (right)
            return (x < hi) ? x + 16'd1 : hi;
        else
            return (x > lo) ? x - 16'd1 : lo;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus run-length debouncer for one raw push-button.
module btn_debounce #(
    parameter int DEB_MS = 8
) (
    input  logic clk_1ms,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CW = $clog2(DEB_MS + 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    // Level flips on the DEB_MS-th consecutive sample that disagrees with it.
    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_MS - 1)) begin
                cnt   <= '0;
                level <= sync_2;
                rise  <= sync_2;
                fall  <= !sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_motion_ctrl.sv
// Player paddle horizontal motion: debounce, last-pressed arbitration,
// ramped step pacing, playfield clamp and a small game-state FSM.
module player_motion_ctrl
    import player_pkg::*;
#(
    parameter int X_MIN       = PF_X_MIN,
    parameter int X_MAX       = PF_X_MAX,
    parameter int X_HOME      = PADDLE_HOME_X,
    parameter int Y_HOME      = PADDLE_HOME_Y,
    parameter int DEB_MS      = 8,
    parameter int SLOW_PERIOD = 4,
    parameter int FAST_PERIOD = 1,
    parameter int RAMP_MS     = 200
) (
    input  logic        clk_1ms,
    input  logic        rst_n,
    input  logic        button,
    input  logic        button1,
    input  logic        game_en,
    input  logic        freeze,
    input  logic        recenter,
    output logic [15:0] x_player,
    output logic [15:0] y_player,
    output logic        moving,
    output logic        dir,
    output logic [1:0]  state
);

    // state    | meaning
    // IDLE     | no motion, waiting for game_en
    // PLAY     | button-driven stepping
    // FREEZE   | position held, pacing/hold cleared
    // RECENTER | 1 px/ms back to X_HOME, buttons ignored

    localparam int PMAX = (SLOW_PERIOD > FAST_PERIOD) ? SLOW_PERIOD : FAST_PERIOD;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int HW   = $clog2(RAMP_MS + 1);
    localparam logic [15:0] XL = 16'(X_MIN);
    localparam logic [15:0] XR = 16'(X_MAX);
    localparam logic [15:0] XH = 16'(X_HOME);

    logic l_lvl, l_rise, l_fall;
    logic r_lvl, r_rise, r_fall;

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_left (
        .clk_1ms (clk_1ms),
        .rst_n   (rst_n),
        .raw     (button),
        .level   (l_lvl),
        .rise    (l_rise),
        .fall    (l_fall)
    );

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_right (
        .clk_1ms (clk_1ms),
        .rst_n   (rst_n),
        .raw     (button1),
        .level   (r_lvl),
        .rise    (r_rise),
        .fall    (r_fall)
    );

    ctrl_state_t   state_q, state_d;
    logic [15:0]   x_q, x_d;
    logic          dir_q;
    logic          last_right, last_right_eff;
    logic          tie, tie_eff;
    logic          req_valid, req_right;
    logic          prev_valid, prev_right, new_run;
    logic [HW-1:0] hold_cnt, hold_eff;
    logic [PW-1:0] pace_cnt, pace_eff, period;
    logic          motion_en, run, step_req, move_right;

    // Rise pulses coincide with the first high level cycle, so fold them in here.
    always_comb begin
        last_right_eff = last_right;
        tie_eff        = tie;
        if (l_rise && r_rise) begin
            tie_eff = 1'b1;
        end else if (l_rise) begin
            last_right_eff = 1'b0;
            tie_eff        = 1'b0;
        end else if (r_rise) begin
            last_right_eff = 1'b1;
            tie_eff        = 1'b0;
        end else if (l_fall || r_fall) begin
            tie_eff = 1'b0;
        end
        req_valid = (l_lvl ^ r_lvl) || (l_lvl && r_lvl && !tie_eff);
        req_right = (l_lvl && r_lvl) ? last_right_eff : r_lvl;
    end

    assign motion_en = (state_q == PLAY) && game_en && !freeze && !recenter;
    assign run       = motion_en && req_valid;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        move_right = req_right;
        step_req   = 1'b0;
        new_run    = !prev_valid || (prev_right != req_right);
        hold_eff   = new_run ? '0 : hold_cnt;
        pace_eff   = new_run ? '0 : pace_cnt;
        period     = (hold_eff < HW'(RAMP_MS)) ? PW'(SLOW_PERIOD) : PW'(FAST_PERIOD);
        case (state_q)
            IDLE: begin
                if (game_en) state_d = PLAY;
            end
            PLAY: begin
                if (recenter)      state_d = RECENTER;
                else if (freeze)   state_d = FREEZE;
                else if (!game_en) state_d = IDLE;
                if (run && (pace_eff == '0)) begin
                    step_req = 1'b1;
                    x_d      = step_clamp(x_q, req_right, XL, XR);
                end
            end
            FREEZE: begin
                if (recenter)    state_d = RECENTER;
                else if (!freeze) state_d = PLAY;
            end
            RECENTER: begin
                move_right = (x_q < XH);
                if (x_q == XH) state_d = IDLE;
                else           x_d = move_right ? x_q + 16'd1 : x_q - 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign moving = (x_d != x_q);

    always_ff @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            x_q        <= XH;
            dir_q      <= 1'b0;
            last_right <= 1'b0;
            tie        <= 1'b0;
            prev_valid <= 1'b0;
            prev_right <= 1'b0;
            hold_cnt   <= '0;
            pace_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            last_right <= last_right_eff;
            tie        <= tie_eff;
            if (moving) dir_q <= move_right;
            if (run) begin
                prev_valid <= 1'b1;
                prev_right <= req_right;
                hold_cnt   <= (hold_eff == HW'(RAMP_MS)) ? hold_eff : hold_eff + 1'b1;
                pace_cnt   <= step_req ? period - 1'b1 : pace_eff - 1'b1;
            end else begin
                prev_valid <= 1'b0;
                hold_cnt   <= '0;
                pace_cnt   <= '0;
            end
        end
    end

    assign x_player = x_q;
    assign y_player = 16'(Y_HOME);
    assign dir      = dir_q;
    assign state    = state_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: vector table, directed corner
// sequences and random button traffic against a timestamp-based reference model.
module tb_player_motion_ctrl;

    localparam int XMIN = 265, XMAX = 613, HOME = 300, YH = 420;
    localparam int DEB = 8, SLOW = 4, FAST = 1, RAMP = 200;
    localparam int S_IDLE = 0, S_PLAY = 1, S_FREEZE = 2, S_REC = 3;

    logic        clk_1ms = 1'b0;
    logic        rst_n = 1'b0;
    logic        button = 1'b0, button1 = 1'b0;
    logic        game_en = 1'b0, freeze = 1'b0, recenter = 1'b0;
    logic [15:0] x_player, y_player;
    logic        moving, dir;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    player_motion_ctrl dut (
        .clk_1ms  (clk_1ms),
        .rst_n    (rst_n),
        .button   (button),
        .button1  (button1),
        .game_en  (game_en),
        .freeze   (freeze),
        .recenter (recenter),
        .x_player (x_player),
        .y_player (y_player),
        .moving   (moving),
        .dir      (dir),
        .state    (state)
    );

    always #5 clk_1ms = ~clk_1ms;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: levels from raw-sample history, arbitration by rise
    // timestamps, pacing by time since run start and time since last step.
    typedef struct packed {
        int         x;
        int         st;
        bit         dir;
        bit         lv_l;
        bit         lv_r;
        int         rt_l;
        int         rt_r;
        logic [9:0] h_l;
        logic [9:0] h_r;
        int         t;
        bit         act;
        bit         adir;
        int         t0;
        int         tlast;
        int         plast;
    } mstate_t;

    function automatic mstate_t m_reset();
        mstate_t s;
        s    = '0;
        s.x  = HOME;
        s.st = S_IDLE;
        return s;
    endfunction

    function automatic bit settled(input logic [9:0] h, input bit lvl);
        for (int i = 1; i <= DEB; i++)
            if (h[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic mstate_t m_step(input mstate_t s, input bit bl, input bit br,
                                       input bit ge, input bit fz, input bit rc);
        mstate_t n;
        bit req_v, req_r, en, step, mdir;
        int nx, hold;
        n = s; n.t = s.t + 1;
        req_v = 1'b0; req_r = 1'b0; step = 1'b0; nx = s.x; mdir = s.dir;
        if (s.lv_l && s.lv_r) begin
            req_v = (s.rt_l != s.rt_r);
            req_r = (s.rt_r > s.rt_l);
        end else if (s.lv_l) begin
            req_v = 1'b1;
        end else if (s.lv_r) begin
            req_v = 1'b1; req_r = 1'b1;
        end
        en = (s.st == S_PLAY) && ge && !fz && !rc;
        if (en && req_v) begin
            if (!s.act || s.adir != req_r) begin
                step = 1'b1; n.act = 1'b1; n.adir = req_r; n.t0 = s.t;
            end else if (s.t - s.tlast >= s.plast) begin
                step = 1'b1;
            end
            if (step) begin
                hold = s.t - n.t0;
                if (hold > RAMP) hold = RAMP;
                n.tlast = s.t;
                n.plast = (hold < RAMP) ? SLOW : FAST;
            end
        end else begin
            n.act = 1'b0;
        end
        if (step) begin
            mdir = req_r;
            if (req_r) begin
                if (s.x < XMAX) nx = s.x + 1;
            end else if (s.x > XMIN) begin
                nx = s.x - 1;
            end
        end
        case (s.st)
            S_IDLE:   if (ge) n.st = S_PLAY;
            S_PLAY:   if (rc) n.st = S_REC; else if (fz) n.st = S_FREEZE; else if (!ge) n.st = S_IDLE;
            S_FREEZE: if (rc) n.st = S_REC; else if (!fz) n.st = S_PLAY;
            default: begin
                if (s.x == HOME) n.st = S_IDLE;
                else begin
                    mdir = (s.x < HOME);
                    nx   = mdir ? s.x + 1 : s.x - 1;
                end
            end
        endcase
        if (nx != s.x) n.dir = mdir;
        n.x = nx;
        if (settled(s.h_l, s.lv_l)) begin
            n.lv_l = !s.lv_l;
            if (!s.lv_l) n.rt_l = n.t;
        end
        if (settled(s.h_r, s.lv_r)) begin
            n.lv_r = !s.lv_r;
            if (!s.lv_r) n.rt_r = n.t;
        end
        n.h_l = {s.h_l[8:0], bl};
        n.h_r = {s.h_r[8:0], br};
        return n;
    endfunction

    mstate_t m;

    always @(posedge clk_1ms or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else        m <= m_step(m, button, button1, game_en, freeze, recenter);
    end

    always @(negedge clk_1ms) begin
        mstate_t nx;
        nx = m_step(m, button, button1, game_en, freeze, recenter);
        check("model x_player", int'(x_player), m.x);
        check("model y_player", int'(y_player), YH);
        check("model moving",   int'(moving),   int'(nx.x != m.x));
        check("model dir",      int'(dir),      int'(m.dir));
        check("model state",    int'(state),    m.st);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_1ms);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; button = 1'b0; button1 = 1'b0;
        game_en = 1'b0; freeze = 1'b0; recenter = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    typedef struct {
        bit bl;
        bit br;
        int n;
        int exp_x;
        int exp_dir;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_x, max_x;
        bit mono;

        vecs[0] = '{1'b1, 1'b0,  5, 300, 0};
        vecs[1] = '{1'b1, 1'b0, 11, 299, 0};
        vecs[2] = '{1'b1, 1'b0, 30, 295, 0};
        vecs[3] = '{1'b0, 1'b1, 50, 310, 1};
        vecs[4] = '{1'b1, 1'b1, 40, 300, 0};
        vecs[5] = '{1'b0, 1'b1, 10, 300, 0};

        // reset values
        tick(1);
        check("reset x_player", int'(x_player), 300);
        check("reset y_player", int'(y_player), 420);
        check("reset moving",   int'(moving),   0);
        check("reset dir",      int'(dir),      0);
        check("reset state",    int'(state),    S_IDLE);
        rst_n = 1'b1;
        tick(1);
        game_en = 1'b1;
        tick(1);
        check("idle->play", int'(state), S_PLAY);
        tick(5);
        check("no buttons x", int'(x_player), 300);

        // table: press pattern held for n cycles from PLAY, then final position
        for (int i = 0; i < 6; i++) begin
            do_reset();
            game_en = 1'b1;
            tick(1);
            button  = vecs[i].bl;
            button1 = vecs[i].br;
            tick(vecs[i].n);
            check($sformatf("vec%0d x_player", i), int'(x_player), vecs[i].exp_x);
            check($sformatf("vec%0d dir", i),      int'(dir),      vecs[i].exp_dir);
        end

        // right hold: latency, slow period, ramp switch, right clamp
        do_reset();
        game_en = 1'b1;
        tick(1);
        button1 = 1'b1;
        tick(10); check("ramp edge10",  int'(x_player), 300);
        tick(1);  check("ramp edge11",  int'(x_player), 301);
        tick(3);  check("ramp edge14",  int'(x_player), 301);
        tick(1);  check("ramp edge15",  int'(x_player), 302);
        tick(196); check("ramp edge211", int'(x_player), 351);
        tick(1);  check("ramp edge212", int'(x_player), 352);
        prev_x = int'(x_player); max_x = prev_x; mono = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (int'(x_player) < prev_x) mono = 1'b0;
            if (int'(x_player) > max_x) max_x = int'(x_player);
            prev_x = int'(x_player);
        end
        check("right monotonic", int'(mono), 1);
        check("right max",       max_x, 613);
        check("right clamp x",   int'(x_player), 613);
        check("right clamp dir", int'(dir), 1);

        // travel left to 266, park in IDLE, then the left clamp
        button1 = 1'b0;
        tick(15);
        button = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            tick(1);
            if (x_player == 16'd266) begin
                game_en = 1'b0;
                break;
            end
        end
        check("reach 266", int'(x_player), 266);
        tick(1);
        check("parked idle", int'(state), S_IDLE);
        button = 1'b0;
        tick(15);
        game_en = 1'b1;
        tick(1);
        check("replay", int'(state), S_PLAY);
        button = 1'b1;
        tick(11);
        check("left clamp step", int'(x_player), 265);
        check("left clamp dir",  int'(dir), 0);
        tick(20);
        check("left clamp hold",   int'(x_player), 265);
        check("left clamp moving", int'(moving), 0);

        // last-pressed arbitration: right, then left joins, then left releases
        button = 1'b0;
        tick(15);
        button1 = 1'b1;
        tick(50);
        button = 1'b1;
        tick(10); check("arb right only",  int'(x_player), 278);
        tick(1);  check("arb left wins",   int'(x_player), 277);
        tick(3);  check("arb left period", int'(x_player), 277);
        tick(1);  check("arb left step2",  int'(x_player), 276);
        button = 1'b0;
        tick(10); check("arb left tail",   int'(x_player), 274);
        tick(1);  check("arb right back",  int'(x_player), 275);
        check("arb right dir", int'(dir), 1);
        tick(4);  check("arb right step2", int'(x_player), 276);
        button1 = 1'b0;
        tick(15);

        // glitch rejection then a real press
        do_reset();
        game_en = 1'b1;
        tick(1);
        button = 1'b1;
        tick(5);
        button = 1'b0;
        tick(20);
        check("glitch ignored", int'(x_player), 300);
        button = 1'b1;
        tick(20);
        check("press after glitch", int'(x_player), 297);
        button = 1'b0;

        // recenter from HOME
        do_reset();
        game_en = 1'b1;
        tick(1);
        recenter = 1'b1;
        tick(1);
        recenter = 1'b0;
        check("home recenter st", int'(state), S_REC);
        tick(1);
        check("home recenter idle", int'(state), S_IDLE);
        check("home recenter x", int'(x_player), 300);

        // freeze at 400, full recenter, then reset mid-recenter
        do_reset();
        game_en = 1'b1;
        tick(1);
        button1 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (x_player == 16'd400) begin
                freeze = 1'b1;
                break;
            end
        end
        check("reach 400", int'(x_player), 400);
        tick(1);
        check("freeze state", int'(state), S_FREEZE);
        tick(20);
        check("freeze hold", int'(x_player), 400);
        recenter = 1'b1;
        tick(1);
        recenter = 1'b0;
        check("recenter state", int'(state), S_REC);
        check("recenter entry x", int'(x_player), 400);
        tick(1);
        check("recenter first", int'(x_player), 399);
        check("recenter moving", int'(moving), 1);
        check("recenter dir", int'(dir), 0);
        tick(99);
        check("recenter home x", int'(x_player), 300);
        check("recenter home moving", int'(moving), 0);
        check("recenter home st", int'(state), S_REC);
        tick(1);
        check("recenter done", int'(state), S_IDLE);
        freeze = 1'b0;
        tick(1);
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (x_player == 16'd400) begin
                freeze = 1'b1;
                break;
            end
        end
        check("reach 400 again", int'(x_player), 400);
        tick(1);
        recenter = 1'b1;
        tick(1);
        recenter = 1'b0;
        tick(30);
        check("mid recenter x", int'(x_player), 370);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset x",      int'(x_player), 300);
        check("async reset state",  int'(state), S_IDLE);
        check("async reset moving", int'(moving), 0);
        check("async reset dir",    int'(dir), 0);
        button1 = 1'b0; freeze = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // random traffic against the model
        game_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 11) == 0) button  = !button;
            if ($urandom_range(0, 11) == 0) button1 = !button1;
            game_en  = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 149) == 0) freeze = !freeze;
            recenter = ($urandom_range(0, 399) == 0);
            tick(1);
        end
        recenter = 1'b0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
